flatten_collector: RTL and testbench

FLATTEN_COLLECTOR -- requirements
Module: flatten_collector

---
 rtl/flatten_pkg.sv | 25 ++
 rtl/flatten_bank.sv | 45 ++++
 rtl/flatten_collector.sv | 108 ++++++++++
 tb/tb_flatten_collector.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/flatten_pkg.sv
// Shared state types and derived sizing for the flatten collector.
package flatten_pkg;

  typedef enum logic {WR_FILL, WR_FULL} wr_state_t;
  typedef enum logic {RD_IDLE, RD_STREAM} rd_state_t;

  function automatic int calc_g(input int num_images, input int num_inputs);
    return num_images / num_inputs;
  endfunction

  function automatic int calc_quota(input int num_images, input int num_inputs,
                                    input int image_size);
    return calc_g(num_images, num_inputs) * image_size;
  endfunction

  function automatic int calc_total(input int num_images, input int image_size);
    return num_images * image_size;
  endfunction

  function automatic int calc_beats(input int num_images, input int image_size,
                                    input int out_lanes);
    return calc_total(num_images, image_size) / out_lanes;
  endfunction

endpackage

// File: rtl/flatten_bank.sv
// One storage bank: a write port per input lane placing pixels at their
// flattened position, and one beat-wide read port.
module flatten_bank
  import flatten_pkg::*;
#(
  parameter int BitSize     = 2,
  parameter int ImageSize   = 9,
  parameter int NumOfImages = 4,
  parameter int NumOfInputs = 2,
  parameter int OutLanes    = 3,
  localparam int Quota = calc_quota(NumOfImages, NumOfInputs, ImageSize),
  localparam int Total = calc_total(NumOfImages, ImageSize),
  localparam int Beats = calc_beats(NumOfImages, ImageSize, OutLanes),
  localparam int CntW  = $clog2(Quota + 1),
  localparam int BeatW = (Beats > 1) ? $clog2(Beats) : 1,
  localparam int AddrW = (Total > 1) ? $clog2(Total) : 1
) (
  input  logic                                clk,
  input  logic [NumOfInputs-1:0]              wr_en,
  input  logic [NumOfInputs-1:0][CntW-1:0]    wr_count,
  input  logic [NumOfInputs-1:0][BitSize-1:0] wr_data,
  input  logic [BeatW-1:0]                    rd_beat,
  output logic [OutLanes-1:0][BitSize-1:0]    rd_data
);

  logic [BitSize-1:0]                 mem [Total];
  logic [NumOfInputs-1:0][AddrW-1:0]  wr_addr;

  // Lane j owns images j, j+N, j+2N, ...; its k-th pixel lands in image k/ImageSize of that set.
  for (genvar j = 0; j < NumOfInputs; j++) begin : g_wr_addr
    assign wr_addr[j] = AddrW'((j + (int'(wr_count[j]) / ImageSize) * NumOfInputs) * ImageSize
                               + int'(wr_count[j]) % ImageSize);
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < NumOfInputs; j++) begin
      if (wr_en[j]) mem[wr_addr[j]] <= wr_data[j];
    end
  end

  for (genvar o = 0; o < OutLanes; o++) begin : g_rd
    assign rd_data[o] = mem[AddrW'(int'(rd_beat) * OutLanes + o)];
  end

endmodule

// File: rtl/flatten_collector.sv
// Collects pixels from several input lanes into a flattened frame and
// streams it out in fixed-width beats through a ping-pong bank pair.
module flatten_collector
  import flatten_pkg::*;
#(
  parameter int BitSize     = 2,
  parameter int ImageSize   = 9,
  parameter int NumOfImages = 4,
  parameter int NumOfInputs = 2,
  parameter int OutLanes    = 3,
  localparam int Quota = calc_quota(NumOfImages, NumOfInputs, ImageSize),
  localparam int Beats = calc_beats(NumOfImages, ImageSize, OutLanes),
  localparam int CntW  = $clog2(Quota + 1),
  localparam int BeatW = (Beats > 1) ? $clog2(Beats) : 1
) (
  input  logic                                clk,
  input  logic                                res_n,
  input  logic [NumOfInputs-1:0]              in_valid,
  input  logic [NumOfInputs-1:0][BitSize-1:0] in_data,
  output logic [NumOfInputs-1:0]              in_ready,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_start,
  output logic                                out_last,
  output logic [OutLanes-1:0][BitSize-1:0]    out_data
);

  wr_state_t                          wr_state;
  rd_state_t                          rd_state;
  logic                               wr_sel;
  logic [NumOfInputs-1:0][CntW-1:0]   lane_cnt;
  logic [BeatW-1:0]                   beat;
  logic [NumOfInputs-1:0]             accept;
  logic [NumOfInputs-1:0]             lane_full;
  logic                               all_full;
  logic                               swap;
  logic                               beat_fire;
  logic [1:0][OutLanes-1:0][BitSize-1:0] bank_rd;

  for (genvar j = 0; j < NumOfInputs; j++) begin : g_lane_full
    assign lane_full[j] = (lane_cnt[j] == CntW'(Quota));
  end

  assign all_full  = &lane_full;
  assign in_ready  = (wr_state == WR_FILL) ? ~lane_full : '0;
  assign accept    = in_valid & in_ready;
  assign swap      = all_full && (rd_state == RD_IDLE);
  assign out_valid = (rd_state == RD_STREAM);
  assign beat_fire = out_valid && out_ready;
  assign out_start = out_valid && (beat == '0);
  assign out_last  = out_valid && (beat == BeatW'(Beats - 1));
  assign out_data  = out_valid ? bank_rd[~wr_sel] : '0;

  // Swapping straight from a just-completed fill keeps the first beat one cycle behind the last pixel.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      wr_state <= WR_FILL;
      wr_sel   <= 1'b0;
      lane_cnt <= '0;
    end else if (swap) begin
      wr_state <= WR_FILL;
      wr_sel   <= ~wr_sel;
      lane_cnt <= '0;
    end else begin
      if (all_full) wr_state <= WR_FULL;
      for (int j = 0; j < NumOfInputs; j++) begin
        if (accept[j]) lane_cnt[j] <= lane_cnt[j] + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      rd_state <= RD_IDLE;
      beat     <= '0;
    end else if (rd_state == RD_IDLE) begin
      if (swap) begin
        rd_state <= RD_STREAM;
        beat     <= '0;
      end
    end else if (beat_fire) begin
      if (beat == BeatW'(Beats - 1)) begin
        rd_state <= RD_IDLE;
        beat     <= '0;
      end else begin
        beat <= beat + BeatW'(1);
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    flatten_bank #(
      .BitSize     (BitSize),
      .ImageSize   (ImageSize),
      .NumOfImages (NumOfImages),
      .NumOfInputs (NumOfInputs),
      .OutLanes    (OutLanes)
    ) u_bank (
      .clk      (clk),
      .wr_en    (accept & {NumOfInputs{wr_sel == 1'(b)}}),
      .wr_count (lane_cnt),
      .wr_data  (in_data),
      .rd_beat  (beat),
      .rd_data  (bank_rd[b])
    );
  end

endmodule

// File: tb/tb_flatten_collector.sv
// Directed bench for flatten_collector: default configuration plus a
// single-beat, four-lane configuration.
module tb_flatten_collector;

  logic             clk = 1'b0;
  logic             res_n;
  logic [1:0]       in_valid;
  logic [1:0][1:0]  in_data;
  logic [1:0]       in_ready;
  logic             out_valid, out_ready, out_start, out_last;
  logic [2:0][1:0]  out_data;

  logic [3:0]       in_valid2;
  logic [3:0][1:0]  in_data2;
  logic [3:0]       in_ready2;
  logic             out_valid2, out_ready2, out_start2, out_last2;
  logic [35:0][1:0] out_data2;
  logic [35:0][1:0] exp2;

  int vectors = 0;
  int miscompares = 0;
  int wr_seed, rd_seed;
  int sent [2];

  always #5 clk = ~clk;

  flatten_collector dut (
    .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_start(out_start), .out_last(out_last),
    .out_data(out_data)
  );

  flatten_collector #(
    .BitSize(2), .ImageSize(9), .NumOfImages(4), .NumOfInputs(4), .OutLanes(36)
  ) dut2 (
    .clk(clk), .res_n(res_n), .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_start(out_start2), .out_last(out_last2),
    .out_data(out_data2)
  );

  // Pixel value sent as the k-th pixel on lane j of a frame tagged by seed.
  function automatic logic [1:0] pix(input int seed, input int j, input int k);
    return 2'((seed + j * 3 + k + k / 4) % 4);
  endfunction

  function automatic logic [1:0] expPix(input int seed, input int n, input int i);
    int img;
    int px;
    img = i / 9;
    px  = i % 9;
    return pix(seed, img % n, (img / n) * 9 + px);
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkBeat(input string tag, input int b);
    logic [2:0][1:0] e;
    for (int o = 0; o < 3; o++) e[o] = expPix(rd_seed, 2, b * 3 + o);
    checkOutput($sformatf("%s_b%0d_valid", tag, b), 128'(out_valid), 128'(1'b1));
    checkOutput($sformatf("%s_b%0d_data", tag, b), 128'(out_data), 128'(e));
    checkOutput($sformatf("%s_b%0d_start", tag, b), 128'(out_start), 128'(b == 0));
    checkOutput($sformatf("%s_b%0d_last", tag, b), 128'(out_last), 128'(b == 11));
  endtask

  // One clock of stimulus on the default instance, entered and left on a falling edge.
  task automatic applyStimulus(input logic [1:0] v, input logic rdy);
    logic [1:0] acc;
    in_valid  = v;
    out_ready = rdy;
    for (int j = 0; j < 2; j++) in_data[j] = pix(wr_seed, j, sent[j]);
    acc = v & in_ready;
    @(posedge clk);
    for (int j = 0; j < 2; j++) if (acc[j]) sent[j]++;
    @(negedge clk);
  endtask

  task automatic sendFrame(input int seed, input logic rdy);
    wr_seed = seed;
    sent[0] = 0;
    sent[1] = 0;
    for (int c = 0; c < 18; c++) applyStimulus(2'b11, rdy);
  endtask

  initial begin
    res_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    in_valid2 = '0; in_data2 = '0; out_ready2 = 1'b0;
    wr_seed = 0; rd_seed = 0; sent[0] = 0; sent[1] = 0;
    repeat (2) @(negedge clk);

    checkOutput("rst_in_ready", 128'(in_ready), 128'(2'b11));
    checkOutput("rst_out_valid", 128'(out_valid), 128'(1'b0));
    checkOutput("rst_out_start", 128'(out_start), 128'(1'b0));
    checkOutput("rst_out_last", 128'(out_last), 128'(1'b0));
    checkOutput("rst_out_data", 128'(out_data), 128'(0));
    checkOutput("rst2_in_ready", 128'(in_ready2), 128'(4'hF));
    checkOutput("rst2_out_valid", 128'(out_valid2), 128'(1'b0));
    res_n = 1'b1;

    // Both lanes streaming, downstream always ready
    sendFrame(1, 1'b1);
    checkOutput("f1_in_ready_low", 128'(in_ready), 128'(2'b00));
    checkOutput("f1_no_valid_yet", 128'(out_valid), 128'(1'b0));
    applyStimulus(2'b00, 1'b1);
    checkOutput("f1_in_ready_back", 128'(in_ready), 128'(2'b11));
    rd_seed = 1;
    for (int b = 0; b < 12; b++) begin
      checkBeat("f1", b);
      applyStimulus(2'b00, 1'b1);
    end
    checkOutput("f1_done", 128'(out_valid), 128'(1'b0));

    // Lane 0 alone reaches quota; lane 1 later completes the frame
    wr_seed = 2; sent[0] = 0; sent[1] = 0;
    for (int c = 0; c < 18; c++) applyStimulus(2'b01, 1'b1);
    checkOutput("l0_in_ready", 128'(in_ready), 128'(2'b10));
    checkOutput("l0_no_valid", 128'(out_valid), 128'(1'b0));
    applyStimulus(2'b01, 1'b1);
    checkOutput("l0_still_held", 128'(in_ready), 128'(2'b10));
    checkOutput("l0_count", 128'(sent[0]), 128'(18));
    for (int c = 0; c < 18; c++) applyStimulus(2'b10, 1'b1);
    checkOutput("l1_no_valid_yet", 128'(out_valid), 128'(1'b0));
    applyStimulus(2'b00, 1'b0);

    // Downstream ready toggling: each beat must hold through the stall cycle
    rd_seed = 2;
    for (int b = 0; b < 12; b++) begin
      checkBeat("tog", b);
      applyStimulus(2'b00, 1'b0);
      checkBeat("tog_hold", b);
      applyStimulus(2'b00, 1'b1);
    end
    checkOutput("tog_done", 128'(out_valid), 128'(1'b0));

    // Second frame fills while the first is stalled downstream
    sendFrame(3, 1'b0);
    applyStimulus(2'b00, 1'b0);
    rd_seed = 3;
    sendFrame(4, 1'b0);
    checkOutput("bp_full", 128'(in_ready), 128'(2'b00));
    checkBeat("bp_hold", 0);
    applyStimulus(2'b11, 1'b0);
    checkOutput("bp_no_extra", 128'(sent[0] + sent[1]), 128'(36));
    for (int b = 0; b < 12; b++) begin
      checkBeat("bp_f1", b);
      applyStimulus(2'b00, 1'b1);
    end
    checkOutput("bp_gap", 128'(out_valid), 128'(1'b0));
    checkOutput("bp_gap_ready", 128'(in_ready), 128'(2'b00));
    applyStimulus(2'b00, 1'b1);
    rd_seed = 4;
    for (int b = 0; b < 12; b++) begin
      checkBeat("bp_f2", b);
      applyStimulus(2'b00, 1'b1);
    end
    checkOutput("bp_done", 128'(out_valid), 128'(1'b0));
    checkOutput("bp_done_ready", 128'(in_ready), 128'(2'b11));

    // Reset in the middle of streaming with a partial fill in progress
    sendFrame(5, 1'b1);
    applyStimulus(2'b00, 1'b1);
    rd_seed = 5;
    wr_seed = 6; sent[0] = 0; sent[1] = 0;
    for (int b = 0; b < 6; b++) begin
      checkBeat("mid", b);
      applyStimulus(2'b01, 1'b1);
    end
    res_n = 1'b0;
    applyStimulus(2'b00, 1'b0);
    checkOutput("mid_rst_valid", 128'(out_valid), 128'(1'b0));
    checkOutput("mid_rst_start", 128'(out_start), 128'(1'b0));
    checkOutput("mid_rst_last", 128'(out_last), 128'(1'b0));
    checkOutput("mid_rst_data", 128'(out_data), 128'(0));
    checkOutput("mid_rst_ready", 128'(in_ready), 128'(2'b11));
    res_n = 1'b1;
    repeat (3) applyStimulus(2'b00, 1'b1);
    checkOutput("mid_quiet", 128'(out_valid), 128'(1'b0));
    sendFrame(7, 1'b1);
    applyStimulus(2'b00, 1'b1);
    rd_seed = 7;
    for (int b = 0; b < 12; b++) begin
      checkBeat("post", b);
      applyStimulus(2'b00, 1'b1);
    end
    checkOutput("post_done", 128'(out_valid), 128'(1'b0));

    // Four lanes, one 36-pixel beat
    for (int k = 0; k < 9; k++) begin
      checkOutput($sformatf("d2_ready_k%0d", k), 128'(in_ready2), 128'(4'hF));
      in_valid2 = 4'hF;
      for (int j = 0; j < 4; j++) in_data2[j] = pix(9, j, k);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid2 = '0;
    checkOutput("d2_full", 128'(in_ready2), 128'(4'h0));
    checkOutput("d2_no_valid_yet", 128'(out_valid2), 128'(1'b0));
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 36; i++) exp2[i] = expPix(9, 4, i);
    checkOutput("d2_valid", 128'(out_valid2), 128'(1'b1));
    checkOutput("d2_start", 128'(out_start2), 128'(1'b1));
    checkOutput("d2_last", 128'(out_last2), 128'(1'b1));
    checkOutput("d2_data", 128'(out_data2), 128'(exp2));
    out_ready2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready2 = 1'b0;
    checkOutput("d2_done", 128'(out_valid2), 128'(1'b0));
    checkOutput("d2_ready_again", 128'(in_ready2), 128'(4'hF));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
